// File: rtl/uart_tx_port.sv
// uart_tx_port: byte FIFO fed from the matrix tx bus, drained by an 8N1/8N2 serializer.
// The serial line is driven from a flop so the pin never glitches on state decode.
module uart_tx_port #(
    parameter int unsigned depth = 16,
    parameter int unsigned div   = 1,
    parameter int unsigned stop  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in,
    input  logic                     cke,
    output logic                     out,
    output logic                     busy,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(depth):0]   count,
    output logic                     ovf
);

    localparam int unsigned PtrW   = $clog2(depth);
    localparam int unsigned CountW = PtrW + 1;
    localparam int unsigned BaudW  = (div > 1) ? $clog2(div) : 1;

    localparam logic [BaudW-1:0]  BaudMax   = BaudW'(div - 1);
    localparam logic [CountW-1:0] CountFull = CountW'(depth);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // FIFO state
    logic [7:0]        mem_q [depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              wr_en;
    logic              pop;

    // Serializer state
    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              stop2_q, stop2_d;  // currently in the second stop bit
    logic [7:0]        shift_q, shift_d;
    logic              out_q, out_d;
    logic              bit_end;

    // A write is accepted only when the FIFO was not full before the edge, even if a pop
    // frees a slot on the same edge.
    assign wr_en   = cke && !full_q;
    assign bit_end = (baud_q == '0);

    // Byte storage; no reset needed since the pointers/count qualify every entry.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    // Serializer next state; a pop always restarts a frame with a fresh start bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop2_d = stop2_q;
        shift_d = shift_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    pop = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    baud_d  = BaudMax;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d = BaudMax;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        stop2_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (stop == 2 && !stop2_q) begin
                        stop2_d = 1'b1;
                        baud_d  = BaudMax;
                    end else if (!empty_q) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (pop) begin
            state_d = StStart;
            baud_d  = BaudMax;
            shift_d = mem_q[rd_ptr_q];
        end
    end

    // Line level for the state being entered, registered below.
    always_comb begin
        out_d = 1'b1;
        unique case (state_d)
            StStart: out_d = 1'b0;
            StData:  out_d = shift_d[bit_d];
            default: out_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping: pointers, occupancy and flags computed from the next count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (cke & full_q);

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CountFull);
    end

    // State registers with synchronous reset; reset flushes the FIFO and aborts any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            stop2_q  <= 1'b0;
            shift_q  <= 8'h00;
            out_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop2_q  <= stop2_d;
            shift_q  <= shift_d;
            out_q    <= out_d;
        end
    end

    assign out   = out_q;
    assign busy  = (state_q != StIdle);
    assign empty = empty_q;
    assign full  = full_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: three instances with different depth/div/stop, a serial receiver
// model per instance, and a byte scoreboard filled at write time.
module tb_uart_tx_port;

    localparam int DIVS  [3] = '{4, 1, 2};
    localparam int STOPS [3] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] cke;
    logic [7:0] din [3];
    logic [2:0] line, busy, empty, full, ovf;
    logic [4:0] cnt0;
    logic [2:0] cnt1, cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] sb [3][$];
    int         starts[$];

    logic [2:0] rst_seen = '1;
    logic       mon_act [3] = '{0, 0, 0};
    logic       mon_ok  [3];
    logic [7:0] mon_b   [3];
    int         mon_c   [3];

    always #5 clk = ~clk;

    uart_tx_port #(.depth(16), .div(4), .stop(1)) u_a (
        .clk(clk), .reset(rst[0]), .in(din[0]), .cke(cke[0]), .out(line[0]),
        .busy(busy[0]), .empty(empty[0]), .full(full[0]), .count(cnt0), .ovf(ovf[0])
    );
    uart_tx_port #(.depth(4), .div(1), .stop(1)) u_b (
        .clk(clk), .reset(rst[1]), .in(din[1]), .cke(cke[1]), .out(line[1]),
        .busy(busy[1]), .empty(empty[1]), .full(full[1]), .count(cnt1), .ovf(ovf[1])
    );
    uart_tx_port #(.depth(4), .div(2), .stop(2)) u_c (
        .clk(clk), .reset(rst[2]), .in(din[2]), .cke(cke[2]), .out(line[2]),
        .busy(busy[2]), .empty(empty[2]), .full(full[2]), .count(cnt2), .ovf(ovf[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one byte for one edge; keep says whether the byte must appear on the line.
    task automatic put(input int i, input logic [7:0] b, input bit keep);
        din[i] = b;
        cke[i] = 1'b1;
        if (keep) sb[i].push_back(b);
        @(negedge clk);
        cke[i] = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Receiver model: frames start on the first low level, data sampled mid-bit, start and
    // stop levels checked every cycle, byte compared against the scoreboard at frame end.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int d;
            int f;
            int c;
            d = DIVS[i];
            f = (9 + STOPS[i]) * d;
            if (rst_seen[i]) begin
                mon_act[i] = 1'b0;
            end else if (!mon_act[i] && line[i] == 1'b0) begin
                mon_act[i] = 1'b1;
                mon_c[i]   = 0;
                mon_ok[i]  = 1'b1;
                mon_b[i]   = 8'h00;
                if (i == 1) starts.push_back(cyc);
            end
            if (mon_act[i]) begin
                c = mon_c[i];
                if (c < d && line[i] != 1'b0) mon_ok[i] = 1'b0;
                if (c >= 9 * d && line[i] != 1'b1) mon_ok[i] = 1'b0;
                if (c >= d && c < 9 * d && (c % d) == d / 2) mon_b[i][c / d - 1] = line[i];
                if (c == f - 1) begin
                    if (sb[i].size() == 0) begin
                        check($sformatf("rx%0d_unexpected", i), {23'd0, mon_b[i]}, 32'h1ff);
                    end else begin
                        check($sformatf("rx%0d_frame", i), {mon_ok[i], mon_b[i]},
                              {1'b1, sb[i].pop_front()});
                    end
                    mon_act[i] = 1'b0;
                end else begin
                    mon_c[i] = c + 1;
                end
            end
        end
    end

    initial begin
        rst = '1;
        cke = '0;
        din = '{8'h00, 8'h00, 8'h00};
        tick(3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_out%0d", i), line[i], 1);
            check($sformatf("rst_busy%0d", i), busy[i], 0);
            check($sformatf("rst_empty%0d", i), empty[i], 1);
            check($sformatf("rst_full%0d", i), full[i], 0);
            check($sformatf("rst_ovf%0d", i), ovf[i], 0);
        end
        check("rst_count0", cnt0, 0);
        rst = '0;
        tick(2);

        // Single byte, div=4: start low after edge 1, last stop cycle after edge 40.
        put(0, 8'hA5, 1);
        check("a_count_k", cnt0, 1);
        check("a_busy_k", busy[0], 0);
        tick(1);
        check("a_out_start", line[0], 0);
        check("a_busy_start", busy[0], 1);
        check("a_count_pop", cnt0, 0);
        tick(39);
        check("a_busy_laststop", busy[0], 1);
        check("a_out_laststop", line[0], 1);
        tick(1);
        check("a_busy_done", busy[0], 0);
        check("a_empty_done", empty[0], 1);
        tick(3);

        // Back-to-back, div=1: three contiguous frames.
        starts.delete();
        put(1, 8'h00, 1);
        put(1, 8'hFF, 1);
        put(1, 8'h55, 1);
        tick(28);
        check("b_busy_last", busy[1], 1);
        tick(1);
        check("b_empty_end", empty[1], 1);
        check("b_busy_end", busy[1], 0);
        check("b_frames", starts.size(), 3);
        if (starts.size() >= 3) begin
            check("b_gap1", starts[1] - starts[0], 10);
            check("b_gap2", starts[2] - starts[1], 10);
        end
        tick(3);

        // Overflow, depth=4: b5 dropped.
        put(1, 8'hB0, 1);
        check("o_count0", cnt1, 1);
        put(1, 8'hB1, 1);
        check("o_count1", cnt1, 1);
        check("o_busy1", busy[1], 1);
        put(1, 8'hB2, 1);
        put(1, 8'hB3, 1);
        check("o_full_before", full[1], 0);
        put(1, 8'hB4, 1);
        check("o_full4", full[1], 1);
        check("o_ovf4", ovf[1], 0);
        put(1, 8'hB5, 0);
        check("o_ovf5", ovf[1], 1);
        check("o_count5", cnt1, 4);
        tick(60);
        check("o_drained", empty[1], 1);

        // Full with a pop on the same edge: reset clears ovf, then refill.
        rst[1] = 1'b1;
        tick(1);
        rst[1] = 1'b0;
        check("f_ovf_clr", ovf[1], 0);
        tick(1);
        put(1, 8'hC0, 1);
        put(1, 8'hC1, 1);
        put(1, 8'hC2, 1);
        put(1, 8'hC3, 1);
        put(1, 8'hC4, 1);
        tick(6);
        check("f_full", full[1], 1);
        check("f_busy_laststop", busy[1], 1);
        put(1, 8'hC5, 0);
        check("f_ovf", ovf[1], 1);
        check("f_count", cnt1, 3);
        check("f_busy_restart", busy[1], 1);
        tick(45);

        // stop=2, div=2: 22-cycle frame.
        put(2, 8'h81, 1);
        tick(22);
        check("s_busy_laststop", busy[2], 1);
        tick(1);
        check("s_busy_done", busy[2], 0);
        tick(3);

        // Reset mid-frame during bit 3 of 0x3C with two bytes queued; cke ignored in reset.
        put(0, 8'h3C, 0);
        put(0, 8'hAA, 0);
        put(0, 8'hBB, 0);
        tick(16);
        check("r_busy_pre", busy[0], 1);
        check("r_count_pre", cnt0, 2);
        rst[0] = 1'b1;
        put(0, 8'h77, 0);
        check("r_out", line[0], 1);
        check("r_count", cnt0, 0);
        check("r_busy", busy[0], 0);
        check("r_ovf", ovf[0], 0);
        check("r_empty", empty[0], 1);
        rst[0] = 1'b0;
        tick(1);
        put(0, 8'h12, 1);
        tick(45);
        check("r_after_busy", busy[0], 0);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("sb%0d_drained", i), sb[i].size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
